// File: rtl/wb_frame_src.sv
// Frame source: streams LEN-symbol frames from an internal symbol memory onto a
// Wishbone-classic master port. Optional PAUSE_I input under WB_FRAME_SRC_PAUSE_EN.
module wb_frame_src #(
   parameter int DW    = 2,
   parameter int DEPTH = 8192
) (
   input  logic                     CLK_I,
   input  logic                     RST_I,
   input  logic [31:0]              CFG_DAT_I,
   input  logic [1:0]               CFG_ADR_I,
   input  logic                     CFG_WE_I,
   input  logic                     CFG_STB_I,
   output logic                     CFG_ACK_O,
   input  logic                     MEM_WE_I,
   input  logic [$clog2(DEPTH)-1:0] MEM_ADR_I,
   input  logic [DW-1:0]            MEM_DAT_I,
   output logic [DW-1:0]            DAT_O,
   output logic                     WE_O,
   output logic                     STB_O,
   output logic                     CYC_O,
   input  logic                     ACK_I,
`ifdef WB_FRAME_SRC_PAUSE_EN
   input  logic                     PAUSE_I,
`endif
   output logic                     BUSY_O,
   output logic                     DONE_O,
   output logic [15:0]              FRM_CNT_O
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_XFER, S_GAP, S_FIN} state_t;

   state_t          r_state, w_state_nxt;
   logic [15:0]     r_len, r_nfrm, r_gap, r_gcnt, r_frm_cnt;
   logic [15:0]     r_idx, w_idx_nxt;
   logic [AW-1:0]   r_base, w_base_nxt, w_rd_adr;
   logic            r_ack;
   logic [DW-1:0]   r_mem [DEPTH];
   logic [DW-1:0]   r_rdat;

   logic w_cfg_wr, w_idle, w_ctrl, w_abort, w_start, w_xfer, w_pause;
   logic w_stb, w_acc, w_last_sym, w_last_frm;
   logic w_unused_dat;

   assign w_unused_dat = &{1'b0, CFG_DAT_I[31:16]};

`ifdef WB_FRAME_SRC_PAUSE_EN
   assign w_pause = PAUSE_I;
`else
   assign w_pause = 1'b0;
`endif

   assign w_cfg_wr   = CFG_STB_I & CFG_WE_I;
   assign w_idle     = (r_state == S_IDLE);
   assign w_ctrl     = w_cfg_wr & (CFG_ADR_I == 2'd3);
   assign w_abort    = w_ctrl & CFG_DAT_I[1] & ~w_idle;
   assign w_start    = w_ctrl & CFG_DAT_I[0] & ~CFG_DAT_I[1] & w_idle;
   assign w_xfer     = (r_state == S_XFER);
   assign w_stb      = w_xfer & ~w_pause;
   assign w_acc      = w_stb & ACK_I;
   assign w_last_sym = (r_idx == r_len - 16'd1);
   assign w_last_frm = (r_frm_cnt + 16'd1 == r_nfrm);

   // The FETCH cycle counts toward the inter-frame gap, so GAP itself lasts max(GAP,1)-1 cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_base_nxt  = r_base;
      case (r_state)
         S_IDLE: if (w_start) begin
            w_idx_nxt   = '0;
            w_base_nxt  = '0;
            w_state_nxt = (r_len == 16'd0 || r_nfrm == 16'd0) ? S_FIN : S_FETCH;
         end
         S_FETCH: w_state_nxt = S_XFER;
         S_XFER: if (w_acc) begin
            if (w_last_sym) begin
               w_idx_nxt   = '0;
               w_base_nxt  = r_base + AW'(r_len);
               w_state_nxt = w_last_frm ? S_FIN : ((r_gap > 16'd1) ? S_GAP : S_FETCH);
            end else begin
               w_idx_nxt = r_idx + 16'd1;
            end
         end
         S_GAP:   if (r_gcnt == 16'd0) w_state_nxt = S_FETCH;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) w_state_nxt = S_IDLE;
   end

   // Read address follows the next index so the following symbol is ready without a bubble.
   assign w_rd_adr = w_base_nxt + AW'(w_idx_nxt);

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         r_len     <= '0;
         r_nfrm    <= '0;
         r_gap     <= '0;
         r_gcnt    <= '0;
         r_frm_cnt <= '0;
         r_idx     <= '0;
         r_base    <= '0;
         r_ack     <= 1'b0;
      end else begin
         r_idx  <= w_idx_nxt;
         r_base <= w_base_nxt;
         r_ack  <= w_cfg_wr;
         if (w_cfg_wr && w_idle) begin
            case (CFG_ADR_I)
               2'd0:    r_len  <= CFG_DAT_I[15:0];
               2'd1:    r_nfrm <= CFG_DAT_I[15:0];
               2'd2:    r_gap  <= CFG_DAT_I[15:0];
               default: ;
            endcase
         end
         if (w_start)                  r_frm_cnt <= '0;
         else if (w_acc && w_last_sym) r_frm_cnt <= r_frm_cnt + 16'd1;
         if (w_acc && w_last_sym)                         r_gcnt <= r_gap - 16'd2;
         else if (r_state == S_GAP && r_gcnt != 16'd0)    r_gcnt <= r_gcnt - 16'd1;
      end
   end

   always_ff @(posedge CLK_I) begin
      if (MEM_WE_I) r_mem[MEM_ADR_I] <= MEM_DAT_I;
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) r_rdat <= '0;
      else        r_rdat <= r_mem[w_rd_adr];
   end

   assign CFG_ACK_O = r_ack;
   assign CYC_O     = w_xfer;
   assign STB_O     = w_stb;
   assign WE_O      = w_xfer;
   assign DAT_O     = w_xfer ? r_rdat : '0;
   assign BUSY_O    = ~w_idle;
   assign DONE_O    = (r_state == S_FIN);
   assign FRM_CNT_O = r_frm_cnt;

endmodule

// File: tb/tb_wb_frame_src.sv
// Scoreboard bench for wb_frame_src (default build, DW=4, DEPTH=8).
module tb_wb_frame_src;
   localparam int DW    = 4;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   cfg_dat = '0;
   logic [1:0]    cfg_adr = '0;
   logic          cfg_we = 1'b0, cfg_stb = 1'b0;
   logic          cfg_ack;
   logic          mem_we = 1'b0;
   logic [2:0]    mem_adr = '0;
   logic [DW-1:0] mem_dat = '0;
   logic [DW-1:0] dat;
   logic          we, stb, cyc;
   logic          ack = 1'b0;
   logic          pause = 1'b0;
   logic          busy, done;
   logic [15:0]   frm_cnt;

   wb_frame_src #(.DW(DW), .DEPTH(DEPTH)) dut (
      .CLK_I(clk), .RST_I(rst_n),
      .CFG_DAT_I(cfg_dat), .CFG_ADR_I(cfg_adr), .CFG_WE_I(cfg_we), .CFG_STB_I(cfg_stb),
      .CFG_ACK_O(cfg_ack),
      .MEM_WE_I(mem_we), .MEM_ADR_I(mem_adr), .MEM_DAT_I(mem_dat),
      .DAT_O(dat), .WE_O(we), .STB_O(stb), .CYC_O(cyc), .ACK_I(ack),
`ifdef WB_FRAME_SRC_PAUSE_EN
      .PAUSE_I(pause),
`endif
      .BUSY_O(busy), .DONE_O(done), .FRM_CNT_O(frm_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   logic [DW-1:0] exp_q[$];
   int acc_cnt = 0, done_cnt = 0, cyc_hi_cnt = 0, last_gap = 0, low_run = 0;
   bit counting = 1'b0, prev_cyc = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: pops the expected symbol for every accepted transfer.
   always @(negedge clk) begin
      if (cyc && stb && ack) begin
         acc_cnt++;
         if (exp_q.size() == 0) chk("unexpected transfer", int'(dat), -1);
         else chk("symbol", int'(dat), int'(exp_q.pop_front()));
      end
      if (done) done_cnt++;
      if (cyc)  cyc_hi_cnt++;
      if (prev_cyc && !cyc) begin counting = 1'b1; low_run = 0; end
      if (counting && !cyc) low_run++;
      if (counting && cyc) begin last_gap = low_run; counting = 1'b0; end
      prev_cyc = cyc;
   end

   task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      cfg_stb = 1'b1; cfg_we = 1'b1; cfg_adr = a; cfg_dat = d;
      @(posedge clk); #1;
      cfg_stb = 1'b0; cfg_we = 1'b0;
      @(negedge clk);
      chk("cfg_ack", int'(cfg_ack), 1);
   endtask

   task automatic load_mem(input bit mod4);
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk); #1;
         mem_we = 1'b1; mem_adr = 3'(i); mem_dat = mod4 ? DW'(i % 4) : DW'(i);
      end
      @(posedge clk); #1;
      mem_we = 1'b0;
   endtask

   task automatic wait_done(input int tgt, input string name);
      for (int k = 0; k < 200; k++) begin
         if (done_cnt >= tgt) break;
         @(negedge clk);
      end
      chk(name, int'(done_cnt >= tgt), 1);
   endtask

   task automatic wait_cyc(input string name);
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (cyc) break;
      end
      chk(name, int'(cyc), 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " cyc"}, int'(cyc), 0);
      chk({tag, " stb"}, int'(stb), 0);
      chk({tag, " we"}, int'(we), 0);
      chk({tag, " dat"}, int'(dat), 0);
      chk({tag, " cfg_ack"}, int'(cfg_ack), 0);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " done"}, int'(done), 0);
      chk({tag, " frm_cnt"}, int'(frm_cnt), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, a0, c0;
      #22;
      chk_all_zero("reset");
      #1 rst_n = 1'b1;

      // Two 4-symbol frames with a 3-cycle gap.
      load_mem(1'b1);
      ack = 1'b1;
      cfg_wr(2'd0, 32'd4); cfg_wr(2'd1, 32'd2); cfg_wr(2'd2, 32'd3);
      for (int i = 0; i < 8; i++) exp_q.push_back(DW'(i % 4));
      d0 = done_cnt;
      cfg_wr(2'd3, 32'h1);
      chk("t1 busy after start", int'(busy), 1);
      chk("t1 fetch cycle cyc", int'(cyc), 0);
      @(negedge clk);
      chk("t1 first stb", int'(stb), 1);
      chk("t1 first we", int'(we), 1);
      wait_done(d0 + 1, "t1 done reached");
      repeat (3) @(negedge clk);
      chk("t1 done pulses", done_cnt - d0, 1);
      chk("t1 frm_cnt", int'(frm_cnt), 2);
      chk("t1 gap cycles", last_gap, 3);
      chk("t1 busy idle", int'(busy), 0);
      chk("t1 queue drained", exp_q.size(), 0);

      // Stall 5 cycles on symbol 1.
      load_mem(1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         @(posedge clk); #1;
         mem_we = 1'b1; mem_adr = 3'(i); mem_dat = DW'(i + 1);
      end
      @(posedge clk); #1 mem_we = 1'b0;
      ack = 1'b0;
      cfg_wr(2'd0, 32'd3); cfg_wr(2'd1, 32'd1);
      exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
      a0 = acc_cnt; d0 = done_cnt;
      cfg_wr(2'd3, 32'h1);
      wait_cyc("t2 cyc rise");
      ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2 stall dat", int'(dat), 2);
         chk("t2 stall stb", int'(stb), 1);
      end
      @(posedge clk); #1 ack = 1'b1;
      wait_done(d0 + 1, "t2 done reached");
      chk("t2 accepted", acc_cnt - a0, 3);

      // Address wrap: frame 1 reads 5,6,7,0,1; LEN write while busy is ignored.
      load_mem(1'b0);
      ack = 1'b1;
      cfg_wr(2'd0, 32'd5); cfg_wr(2'd1, 32'd2); cfg_wr(2'd2, 32'd0);
      for (int i = 0; i < 5; i++) exp_q.push_back(DW'(i));
      exp_q.push_back(4'd5); exp_q.push_back(4'd6); exp_q.push_back(4'd7);
      exp_q.push_back(4'd0); exp_q.push_back(4'd1);
      d0 = done_cnt;
      cfg_wr(2'd3, 32'h1);
      cfg_wr(2'd0, 32'd7);
      wait_done(d0 + 1, "t3 done reached");
      @(negedge clk);
      chk("t3 gap cycles", last_gap, 1);
      chk("t3 frm_cnt", int'(frm_cnt), 2);
      chk("t3 queue drained", exp_q.size(), 0);

      // Abort after two accepted symbols of a 10-symbol frame.
      ack = 1'b0;
      cfg_wr(2'd0, 32'd10); cfg_wr(2'd1, 32'd1);
      exp_q.push_back(4'd0); exp_q.push_back(4'd1);
      a0 = acc_cnt; d0 = done_cnt;
      cfg_wr(2'd3, 32'h1);
      wait_cyc("t4 cyc rise");
      ack = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 ack = 1'b0;
      cfg_wr(2'd3, 32'h2);
      chk("t4 abort cyc", int'(cyc), 0);
      chk("t4 abort busy", int'(busy), 0);
      repeat (5) @(negedge clk);
      chk("t4 no done", done_cnt - d0, 0);
      chk("t4 frm_cnt", int'(frm_cnt), 0);
      chk("t4 accepted", acc_cnt - a0, 2);

      // NFRM=0: immediate FIN, no bus activity.
      cfg_wr(2'd1, 32'd0);
      d0 = done_cnt; c0 = cyc_hi_cnt;
      cfg_wr(2'd3, 32'h1);
      chk("t5 done in fin", int'(done), 1);
      repeat (5) @(negedge clk);
      chk("t5 done pulses", done_cnt - d0, 1);
      chk("t5 no cyc", cyc_hi_cnt - c0, 0);
      chk("t5 busy idle", int'(busy), 0);

      // Reset asserted mid-XFER drops everything asynchronously.
      cfg_wr(2'd1, 32'd1); cfg_wr(2'd0, 32'd4);
      exp_q.push_back(4'd0);
      cfg_wr(2'd3, 32'h1);
      wait_cyc("t6 cyc rise");
      ack = 1'b1;
      @(posedge clk); #1 ack = 1'b0;
      chk("t6 dat before reset", int'(dat), 1);
      #2 rst_n = 1'b0; ack = 1'b1;
      #1 chk_all_zero("t6 async reset");
      @(negedge clk) rst_n = 1'b1;
      c0 = cyc_hi_cnt;
      repeat (4) @(negedge clk);
      chk("t6 no cyc after release", cyc_hi_cnt - c0, 0);
      ack = 1'b0;
      cfg_wr(2'd3, 32'h1);
      chk("t6 len cleared gives fin", int'(done), 1);
      repeat (2) @(negedge clk);
      chk("final queue drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
